nonce_scan: RTL and testbench
=============================

NONCE_SCAN -- requirements
Module: nonce_scan

Interface
REQ-001 Parameter NUM_NONCES, default 16, number of consecutive hash words scanned; legal range 1..32.
REQ-002 Parameter TARGET_DEFAULT, default 32'h0000_FFFF, target loaded at reset.
REQ-003 clk  input  1  single clock; mem_clk is driven from it.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  level sampled in IDLE; begins a scan.
REQ-006 result_addr  input  16  base address of hash word for nonce 0, as written by bitcoin_hash output_addr.
REQ-007 target  input  32  unsigned difficulty threshold, sampled on the accepted start.
REQ-008 mem_read_data  input  32  memory read data.
REQ-009 mem_clk  output  1  equals clk.
REQ-010 mem_we  output  1  memory write enable.
REQ-011 mem_addr  output  16  memory address.
REQ-012 mem_write_data  output  32  memory write data.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 found  output  1  at least one hash word < target.
REQ-015 best_nonce  output  5  nonce index of the minimum hash word.
REQ-016 best_hash  output  32  minimum hash word value.
REQ-017 match_count  output  6  number of hash words < target.

Function
REQ-018 States SHALL be IDLE, ISSUE, DRAIN, WB, DONE; only IDLE accepts start; start in any other state is ignored.
REQ-019 Memory read latency is one cycle: address on mem_addr in cycle N yields data on mem_read_data in cycle N+1.
REQ-020 IDLE, start=1: latch target and result_addr, clear found/match_count, best_hash<=32'hFFFF_FFFF, best_nonce<=0, go to ISSUE.
REQ-021 ISSUE: mem_addr = result_addr + i for i = 0..NUM_NONCES-1, one per cycle, mem_we=0; after the last issue go to DRAIN.
REQ-022 Each cycle from the second ISSUE cycle through DRAIN, compare the word returned for nonce i-1 (unsigned).
REQ-023 Word < latched target: match_count increments and found sets.
REQ-024 Word < best_hash: best_hash and best_nonce update; equal values keep the earlier (lower) nonce.
REQ-025 Address arithmetic is 16-bit modulo; result_addr + i wraps past 16'hFFFF.
REQ-026 DRAIN lasts one cycle, then go to WB if CONFIG REQ-033 applies, otherwise go to DONE.
REQ-027 DONE: done=1 for exactly one cycle, then return to IDLE.
REQ-028 found, best_nonce, best_hash and match_count hold their values until the next accepted start.
REQ-029 Latency without writeback: start sampled in cycle 0, done high in cycle NUM_NONCES+2 (cycle 18 for the default NUM_NONCES).
REQ-030 target = 0: no word matches; found=0 and match_count=0, and best_* still report the minimum.

Reset
REQ-031 reset_n low, asynchronously: state IDLE; done, mem_we, found=0; mem_addr, mem_write_data, match_count, best_nonce=0; best_hash=32'hFFFF_FFFF; latched target=TARGET_DEFAULT.
REQ-032 Reset mid-scan SHALL abort the scan with no memory write; the first start after release begins a full scan.

Configuration
REQ-033 Macro NONCE_SCAN_WRITEBACK_EN defined: WB is one cycle.
  - mem_we=1, mem_addr=result_addr+NUM_NONCES.
  - mem_write_data = {found, 10'b0, best_nonce, 10'b0, match_count}.
  - done then follows one cycle later (cycle NUM_NONCES+3).
REQ-034 Macro undefined: the WB state is absent and mem_we is constant 0.

Verification
REQ-035 Words 0x8000_0000+i for i=0..15, target=0x0001_0000 -> found=0, match_count=0, best_nonce=0, best_hash=0x8000_0000, done at cycle 18.
REQ-036 Word[5]=0x0000_1234, word[9]=0x0000_0042, rest 0xFFFF_FFFF, target=0x0000_FFFF -> found=1, match_count=2, best_nonce=9, best_hash=0x0000_0042.
REQ-037 Words[3] and [7] both 0x0000_0010, rest larger -> best_nonce=3 (tie keeps the lower nonce).
REQ-038 result_addr=16'hFFF8 -> addresses wrap FFF8..FFFF then 0000..0007; with WRITEBACK_EN, the summary is written at 0x0008.
REQ-039 Reset pulsed in cycle 6 of a scan, with WRITEBACK_EN defined -> outputs return to reset values, no mem_we pulse, and the next start produces correct results.
REQ-040 WRITEBACK_EN defined, REQ-036 data -> mem_write_data=0x8009_0002 with mem_we high for one cycle, done at cycle 19.

Source files
------------

// File: rtl/nonce_scan.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | nonce_scan: scans NUM_NONCES hash words, reports the minimum and the   |
// | count below target. Optional summary write: NONCE_SCAN_WRITEBACK_EN.  |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module nonce_scan #(
    parameter int          NUM_NONCES     = 16,
    parameter logic [31:0] TARGET_DEFAULT = 32'h0000_FFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] result_addr,
    input  logic [31:0] target,
    input  logic [31:0] mem_read_data,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        done,
    output logic        found,
    output logic [4:0]  best_nonce,
    output logic [31:0] best_hash,
    output logic [5:0]  match_count
);

    localparam logic [4:0] c_LAST_IDX = 5'(NUM_NONCES - 1);

`ifdef NONCE_SCAN_WRITEBACK_EN
    localparam logic [15:0] c_WB_OFFSET = 16'(NUM_NONCES);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        DRAIN = 3'd2,
        WB    = 3'd3,
        DONE  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        DRAIN = 3'd2,
        DONE  = 3'd4
    } state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] target_q, target_d;
    logic [15:0] base_q, base_d;
    logic [4:0]  issue_idx_q, issue_idx_d;
    logic        rd_valid_q, rd_valid_d;
    logic [4:0]  rd_idx_q, rd_idx_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic        done_q, done_d;
    logic        found_q, found_d;
    logic [4:0]  best_nonce_q, best_nonce_d;
    logic [31:0] best_hash_q, best_hash_d;
    logic [5:0]  match_count_q, match_count_d;
`ifdef NONCE_SCAN_WRITEBACK_EN
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_write_data_q, mem_write_data_d;
`endif

    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        base_d        = base_q;
        issue_idx_d   = issue_idx_q;
        rd_valid_d    = 1'b0;
        rd_idx_d      = issue_idx_q;
        mem_addr_d    = mem_addr_q;
        done_d        = 1'b0;
        found_d       = found_q;
        best_nonce_d  = best_nonce_q;
        best_hash_d   = best_hash_q;
        match_count_d = match_count_q;
`ifdef NONCE_SCAN_WRITEBACK_EN
        mem_we_d         = 1'b0;
        mem_write_data_d = mem_write_data_q;
`endif

        // Data for the address issued last cycle is on mem_read_data now.
        if (rd_valid_q) begin
            if (mem_read_data < target_q) begin
                match_count_d = match_count_q + 6'd1;
                found_d       = 1'b1;
            end
            if (mem_read_data < best_hash_q) begin
                best_hash_d  = mem_read_data;
                best_nonce_d = rd_idx_q;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    target_d      = target;
                    base_d        = result_addr;
                    found_d       = 1'b0;
                    match_count_d = 6'd0;
                    best_hash_d   = 32'hFFFF_FFFF;
                    best_nonce_d  = 5'd0;
                    issue_idx_d   = 5'd0;
                    mem_addr_d    = result_addr;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                rd_valid_d = 1'b1;
                if (issue_idx_q == c_LAST_IDX) begin
                    state_d = DRAIN;
                end else begin
                    issue_idx_d = issue_idx_q + 5'd1;
                    mem_addr_d  = base_q + 16'(issue_idx_q) + 16'd1;
                end
            end
            DRAIN: begin
`ifdef NONCE_SCAN_WRITEBACK_EN
                // The last compare lands this cycle, so pack the _d values.
                state_d          = WB;
                mem_we_d         = 1'b1;
                mem_addr_d       = base_q + c_WB_OFFSET;
                mem_write_data_d = {found_d, 10'b0, best_nonce_d, 10'b0, match_count_d};
`else
                state_d = DONE;
                done_d  = 1'b1;
`endif
            end
`ifdef NONCE_SCAN_WRITEBACK_EN
            WB: begin
                state_d = DONE;
                done_d  = 1'b1;
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            target_q      <= TARGET_DEFAULT;
            base_q        <= 16'd0;
            issue_idx_q   <= 5'd0;
            rd_valid_q    <= 1'b0;
            rd_idx_q      <= 5'd0;
            mem_addr_q    <= 16'd0;
            done_q        <= 1'b0;
            found_q       <= 1'b0;
            best_nonce_q  <= 5'd0;
            best_hash_q   <= 32'hFFFF_FFFF;
            match_count_q <= 6'd0;
`ifdef NONCE_SCAN_WRITEBACK_EN
            mem_we_q         <= 1'b0;
            mem_write_data_q <= 32'd0;
`endif
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            base_q        <= base_d;
            issue_idx_q   <= issue_idx_d;
            rd_valid_q    <= rd_valid_d;
            rd_idx_q      <= rd_idx_d;
            mem_addr_q    <= mem_addr_d;
            done_q        <= done_d;
            found_q       <= found_d;
            best_nonce_q  <= best_nonce_d;
            best_hash_q   <= best_hash_d;
            match_count_q <= match_count_d;
`ifdef NONCE_SCAN_WRITEBACK_EN
            mem_we_q         <= mem_we_d;
            mem_write_data_q <= mem_write_data_d;
`endif
        end
    end

    assign mem_clk     = clk;
    assign mem_addr    = mem_addr_q;
    assign done        = done_q;
    assign found       = found_q;
    assign best_nonce  = best_nonce_q;
    assign best_hash   = best_hash_q;
    assign match_count = match_count_q;
`ifdef NONCE_SCAN_WRITEBACK_EN
    assign mem_we         = mem_we_q;
    assign mem_write_data = mem_write_data_q;
`else
    assign mem_we         = 1'b0;
    assign mem_write_data = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nonce_scan.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_nonce_scan: directed and random scans against a reference model.   |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_nonce_scan;

    localparam int N = 16;
`ifdef NONCE_SCAN_WRITEBACK_EN
    localparam int WB = 1;
`else
    localparam int WB = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] result_addr = 16'd0;
    logic [31:0] target = 32'd0;
    logic [31:0] mem_read_data = 32'd0;
    logic        mem_clk, mem_we, done, found;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data, best_hash;
    logic [4:0]  best_nonce;
    logic [5:0]  match_count;

    logic [31:0] words [N];
    logic [15:0] mem_base = 16'd0;
    int tests = 0;
    int fails = 0;

    nonce_scan #(.NUM_NONCES(N), .TARGET_DEFAULT(32'h0000_FFFF)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .result_addr(result_addr),
        .target(target), .mem_read_data(mem_read_data), .mem_clk(mem_clk),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .done(done), .found(found), .best_nonce(best_nonce), .best_hash(best_hash),
        .match_count(match_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_lookup(input logic [15:0] a);
        logic [15:0] off;
        off = a - mem_base;
        if (off < 16'(N)) return words[int'(off)];
        return 32'hDEAD_BEEF;
    endfunction

    always @(posedge clk) mem_read_data <= mem_lookup(mem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_scan(input string name, input logic [15:0] base,
                            input logic [31:0] tgt, input int hold);
        logic        e_found;
        logic [5:0]  e_cnt;
        logic [4:0]  e_bn;
        logic [31:0] e_bh;
        int done_cyc, we_cnt, addr_err;
        e_found = 1'b0; e_cnt = 6'd0; e_bn = 5'd0; e_bh = 32'hFFFF_FFFF;
        for (int i = 0; i < N; i++) begin
            if (words[i] < tgt) begin e_cnt++; e_found = 1'b1; end
            if (words[i] < e_bh) begin e_bh = words[i]; e_bn = 5'(i); end
        end
        mem_base = base;
        done_cyc = -1; we_cnt = 0; addr_err = 0;
        @(negedge clk);
        start = 1'b1; result_addr = base; target = tgt;
        @(posedge clk);
        for (int c = 1; c <= N + 8; c++) begin
            @(negedge clk);
            if (c > hold) start = 1'b0;
            result_addr = 16'($urandom);
            target = $urandom;
            if (c <= N && mem_addr !== base + 16'(c - 1)) addr_err++;
            if (mem_we === 1'b1) begin
                we_cnt++;
                check({name, " wb_cycle"}, 32'(c), 32'(N + 2));
                check({name, " wb_addr"}, 32'(mem_addr), 32'(base + 16'(N)));
                check({name, " wb_data"}, mem_write_data,
                      {e_found, 10'b0, e_bn, 10'b0, e_cnt});
            end
            if (done_cyc > 0 && c == done_cyc + 1) check({name, " done_pulse"}, 32'(done), 32'd0);
            if (done === 1'b1 && done_cyc < 0) done_cyc = c;
        end
        check({name, " addr_seq_errors"}, 32'(addr_err), 32'd0);
        check({name, " done_cycle"}, 32'(done_cyc), 32'(N + 2 + WB));
        check({name, " we_pulses"}, 32'(we_cnt), 32'(WB));
        check({name, " found"}, 32'(found), 32'(e_found));
        check({name, " match_count"}, 32'(match_count), 32'(e_cnt));
        check({name, " best_nonce"}, 32'(best_nonce), 32'(e_bn));
        check({name, " best_hash"}, best_hash, e_bh);
    endtask

    task automatic check_reset_values(input string name);
        check({name, " done"}, 32'(done), 32'd0);
        check({name, " mem_we"}, 32'(mem_we), 32'd0);
        check({name, " found"}, 32'(found), 32'd0);
        check({name, " mem_addr"}, 32'(mem_addr), 32'd0);
        check({name, " mem_wdata"}, mem_write_data, 32'd0);
        check({name, " match_count"}, 32'(match_count), 32'd0);
        check({name, " best_nonce"}, 32'(best_nonce), 32'd0);
        check({name, " best_hash"}, best_hash, 32'hFFFF_FFFF);
    endtask

    initial begin
        int we_seen;
        #2 reset_n = 1'b0;
        #1 check_reset_values("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // No word below target; minimum is the first word.
        for (int i = 0; i < N; i++) words[i] = 32'h8000_0000 + 32'(i);
        run_scan("no_match", 16'h0100, 32'h0001_0000, 1);

        // Two matches, minimum at nonce 9; start held high to be ignored mid-scan.
        for (int i = 0; i < N; i++) words[i] = 32'hFFFF_FFFF;
        words[5] = 32'h0000_1234; words[9] = 32'h0000_0042;
        run_scan("two_match", 16'h2000, 32'h0000_FFFF, 3);

        // Tie between nonces 3 and 7.
        for (int i = 0; i < N; i++) words[i] = 32'h0000_0100 + 32'(i);
        words[3] = 32'h0000_0010; words[7] = 32'h0000_0010;
        run_scan("tie", 16'h0040, 32'h0000_0080, 1);

        // Address wrap past 16'hFFFF.
        for (int i = 0; i < N; i++) words[i] = $urandom;
        run_scan("wrap", 16'hFFF8, 32'h4000_0000, 1);

        // All-ones words never beat the initial best and never match.
        for (int i = 0; i < N; i++) words[i] = 32'hFFFF_FFFF;
        run_scan("all_ones", 16'h1234, 32'hFFFF_FFFF, 1);

        // Zero target: nothing matches, minimum still reported.
        for (int i = 0; i < N; i++) words[i] = $urandom_range(32'h0000_0000, 32'h0000_0FFF);
        run_scan("target_zero", 16'h0800, 32'h0000_0000, 1);

        // Reset mid-scan.
        for (int i = 0; i < N; i++) words[i] = $urandom;
        mem_base = 16'h0300;
        @(negedge clk);
        start = 1'b1; result_addr = 16'h0300; target = 32'hFFFF_FFFF;
        @(posedge clk);
        repeat (6) @(negedge clk);
        start = 1'b0;
        #1 reset_n = 1'b0;
        #1 check_reset_values("midreset");
        we_seen = 0;
        for (int c = 0; c < N + 4; c++) begin
            @(negedge clk);
            if (c == 2) reset_n = 1'b1;
            if (mem_we === 1'b1 || done === 1'b1) we_seen++;
        end
        check("midreset no_we_or_done", 32'(we_seen), 32'd0);
        run_scan("after_reset", 16'h0300, 32'h8000_0000, 1);

        // Random scans with mixed small words and duplicated minima.
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < N; i++)
                words[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 32'h0002_0000) : $urandom;
            if (t % 2 == 0) words[$urandom_range(0, N - 1)] = words[$urandom_range(0, N - 1)];
            run_scan($sformatf("rand%0d", t), 16'($urandom), $urandom_range(0, 32'h0002_0000), 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
